// File: rtl/beat_seq_pkg.sv
// Shared definitions for the beat sequencer: run-state encoding,
// default geometry and an index-width helper.
package beat_seq_pkg;

  localparam int DEF_NUM_TRACKS = 4;
  localparam int DEF_STEPS      = 16;
  localparam int DEF_DIV_WIDTH  = 26;

  // Encoding is visible on run_state, so the values are pinned.
  typedef enum logic [1:0] {
    STOPPED = 2'd0,
    RUNNING = 2'd1,
    PAUSED  = 2'd2
  } run_state_e;

  // Width of an index into n entries; never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/tempo_divider.sv
// Beat-period divider. Counts clock cycles while running and raises
// tick for the cycle in which the count has reached tempo_div. The
// compare is ">=" so that lowering tempo_div below the current count
// ticks at once instead of wrapping through the whole counter range.
module tempo_divider
  import beat_seq_pkg::*;
#(
  parameter int DIV_WIDTH = DEF_DIV_WIDTH
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 run,
  input  logic                 clear,
  input  logic [DIV_WIDTH-1:0] tempo_div,
  output logic                 tick
);

  logic [DIV_WIDTH-1:0] count;
  logic                 terminal;

  assign terminal = (count >= tempo_div);

  // A clear in the same cycle suppresses the tick: stop wins over a beat.
  assign tick = run & ~clear & terminal;

  // Count up while running, restart after each tick, hold while not running.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (run) begin
      if (terminal) begin
        count <= '0;
      end else begin
        count <= count + 1'b1;
      end
    end
  end

endmodule

// File: rtl/beat_sequencer.sv
// Step sequencer: per-track step patterns loaded over a four-phase
// handshake, a play/pause/stop transport FSM, and registered per-track
// speaker enables following the current beat.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   STOPPED | rewound to beat 0, divider held clear, speakers off
//   RUNNING | divider counting, beats advance on each tick, speakers on
//   PAUSED  | beat and divider count frozen, speakers off
module beat_sequencer
  import beat_seq_pkg::*;
#(
  parameter int NUM_TRACKS = DEF_NUM_TRACKS,
  parameter int STEPS      = DEF_STEPS,
  parameter int DIV_WIDTH  = DEF_DIV_WIDTH
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic [STEPS-1:0]                  pattern,
  input  logic [idx_width(NUM_TRACKS)-1:0]  track_sel,
  input  logic                              load_req,
  output logic                              load_ack,
  input  logic                              play_cmd,
  input  logic                              stop_cmd,
  input  logic [DIV_WIDTH-1:0]              tempo_div,
  output logic                              beat_tick,
  output logic [idx_width(STEPS)-1:0]       current_beat,
  output logic [NUM_TRACKS-1:0]             track_play,
  output logic [1:0]                        run_state,
  output logic [STEPS-1:0]                  pattern_view
);

  run_state_e      state;
  logic [STEPS-1:0] pattern_reg [NUM_TRACKS];

  logic div_run;
  logic div_clear;
  logic div_tick;
  logic load_fire;
  logic sel_valid;

  // track_sel may address past the last track when NUM_TRACKS is not a
  // power of two; such selects neither write nor read anything.
  assign sel_valid = (32'(track_sel) < NUM_TRACKS);

  assign div_run   = (state == RUNNING);
  assign div_clear = stop_cmd | (state == STOPPED);

  tempo_divider #(
    .DIV_WIDTH (DIV_WIDTH)
  ) u_tempo_divider (
    .clock     (clock),
    .reset     (reset),
    .run       (div_run),
    .clear     (div_clear),
    .tempo_div (tempo_div),
    .tick      (div_tick)
  );

  // A write happens only on the rising phase of the handshake; ack then
  // blocks further writes until the requester has dropped load_req.
  assign load_fire = load_req & ~load_ack;

  // Pattern storage and four-phase load handshake, live in every state.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      load_ack <= 1'b0;
      for (int t = 0; t < NUM_TRACKS; t++) begin
        pattern_reg[t] <= '0;
      end
    end else begin
      if (load_fire) begin
        load_ack <= 1'b1;
        if (sel_valid) begin
          pattern_reg[track_sel] <= pattern;
        end
      end else if (!load_req) begin
        load_ack <= 1'b0;
      end
    end
  end

  // Red LED view of the selected track's stored pattern.
  always_comb begin
    pattern_view = '0;
    if (sel_valid) begin
      pattern_view = pattern_reg[track_sel];
    end
  end

  // Transport FSM with registered beat position, tick and speaker enables.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= STOPPED;
      current_beat <= '0;
      beat_tick    <= 1'b0;
      track_play   <= '0;
    end else begin
      // div_tick is already masked by stop_cmd through the divider clear.
      beat_tick <= div_tick;

      for (int t = 0; t < NUM_TRACKS; t++) begin
        track_play[t] <= (state == RUNNING) & pattern_reg[t][current_beat];
      end

      if (stop_cmd) begin
        state        <= STOPPED;
        current_beat <= '0;
      end else begin
        if (div_tick) begin
          current_beat <= current_beat + 1'b1;
        end
        if (play_cmd) begin
          case (state)
            STOPPED: state <= RUNNING;
            RUNNING: state <= PAUSED;
            PAUSED:  state <= RUNNING;
            default: state <= STOPPED;
          endcase
        end
      end
    end
  end

  assign run_state = state;

endmodule

// File: tb/tb_beat_sequencer.sv
// Directed bench for beat_sequencer. Stimulus pushes the beat index
// expected at every beat_tick and the pattern expected at every load_ack
// rise; a negedge monitor pops and compares when the DUT presents them.
module tb_beat_sequencer;

  logic        clock;
  logic        reset;
  logic [15:0] pattern;
  logic [1:0]  track_sel;
  logic        load_req;
  logic        load_ack;
  logic        play_cmd;
  logic        stop_cmd;
  logic [25:0] tempo_div;
  logic        beat_tick;
  logic [3:0]  current_beat;
  logic [3:0]  track_play;
  logic [1:0]  run_state;
  logic [15:0] pattern_view;

  int checks   = 0;
  int failures = 0;

  logic [3:0]  exp_beats [$];
  logic [15:0] exp_loads [$];
  logic        prev_ack;

  beat_sequencer dut (
    .clock        (clock),
    .reset        (reset),
    .pattern      (pattern),
    .track_sel    (track_sel),
    .load_req     (load_req),
    .load_ack     (load_ack),
    .play_cmd     (play_cmd),
    .stop_cmd     (stop_cmd),
    .tempo_div    (tempo_div),
    .beat_tick    (beat_tick),
    .current_beat (current_beat),
    .track_play   (track_play),
    .run_state    (run_state),
    .pattern_view (pattern_view)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic void check(input string name, input logic [31:0] act,
                                input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endfunction

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic pulse_play();
    play_cmd = 1'b1;
    cyc();
    play_cmd = 1'b0;
  endtask

  task automatic pulse_stop();
    stop_cmd = 1'b1;
    cyc();
    stop_cmd = 1'b0;
  endtask

  task automatic do_load(input logic [1:0] t, input logic [15:0] p);
    int n;
    track_sel = t;
    pattern   = p;
    load_req  = 1'b1;
    exp_loads.push_back(p);
    n = 0;
    do begin
      cyc();
      n++;
    end while (!load_ack && n < 8);
    check("load_ack_rise", 32'(load_ack), 32'd1);
    check("load_ack_latency", 32'(n), 32'd1);
    load_req = 1'b0;
    n = 0;
    do begin
      cyc();
      n++;
    end while (load_ack && n < 8);
    check("load_ack_fall", 32'(load_ack), 32'd0);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_run_state"}, 32'(run_state), 32'd0);
    check({tag, "_beat"}, 32'(current_beat), 32'd0);
    check({tag, "_beat_tick"}, 32'(beat_tick), 32'd0);
    check({tag, "_track_play"}, 32'(track_play), 32'd0);
    check({tag, "_load_ack"}, 32'(load_ack), 32'd0);
    for (int t = 0; t < 4; t++) begin
      track_sel = 2'(t);
      #1;
      check({tag, "_pattern_view"}, 32'(pattern_view), 32'd0);
    end
  endtask

  // Scoreboard monitor: beat value on every tick, pattern on every ack rise.
  always @(negedge clock) begin
    logic [3:0]  eb;
    logic [15:0] ep;
    if (reset) begin
      prev_ack = 1'b0;
    end else begin
      if (beat_tick) begin
        if (exp_beats.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_tick actual_beat=%0d required=no_tick", current_beat);
        end else begin
          eb = exp_beats.pop_front();
          check("beat_on_tick", 32'(current_beat), 32'(eb));
        end
      end
      if (load_ack && !prev_ack) begin
        if (exp_loads.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_ack actual_view=0x%0h required=no_ack", pattern_view);
        end else begin
          ep = exp_loads.pop_front();
          check("pattern_after_load", 32'(pattern_view), 32'(ep));
        end
      end
      prev_ack = load_ack;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset     = 1'b1;
    pattern   = '0;
    track_sel = '0;
    load_req  = 1'b0;
    play_cmd  = 1'b0;
    stop_cmd  = 1'b0;
    tempo_div = 26'd3;
    repeat (3) @(posedge clock);
    #1;
    check_idle_outputs("in_reset");
    reset = 1'b0;
    cyc();
    check_idle_outputs("after_reset");

    // Bar at tempo 3 with track 0 = 8001: sounds on beats 0 and 15 only.
    do_load(2'd0, 16'h8001);
    for (int b = 1; b <= 16; b++) exp_beats.push_back(4'(b));
    pulse_play();
    check("run_after_play", 32'(run_state), 32'd1);
    for (int k = 0; k < 16; k++) begin
      cyc();
      cyc();
      check("bar_beat", 32'(current_beat), 32'(k));
      check("bar_track_play", 32'(track_play), (k == 0 || k == 15) ? 32'h1 : 32'h0);
      cyc();
      cyc();
    end
    pulse_stop();
    check("stopped_after_bar", 32'(run_state), 32'd0);
    check("beat_after_stop", 32'(current_beat), 32'd0);

    // Pause at beat 5, load while paused, resume with the held count.
    do_load(2'd1, 16'h0020);
    for (int b = 1; b <= 5; b++) exp_beats.push_back(4'(b));
    pulse_play();
    repeat (20) cyc();
    check("beat_before_pause", 32'(current_beat), 32'd5);
    pulse_play();
    check("paused_state", 32'(run_state), 32'd2);
    check("play_last_run_cycle", 32'(track_play), 32'h2);
    cyc();
    check("paused_track_play", 32'(track_play), 32'h0);
    do_load(2'd2, 16'h0040);
    repeat (5) cyc();
    check("paused_beat_hold", 32'(current_beat), 32'd5);
    check("paused_track_play_late", 32'(track_play), 32'h0);
    check("paused_state_hold", 32'(run_state), 32'd2);
    exp_beats.push_back(4'd6);
    pulse_play();
    check("resumed_state", 32'(run_state), 32'd1);
    cyc();
    cyc();
    check("resume_beat_held", 32'(current_beat), 32'd5);
    cyc();
    check("resume_early_tick_beat", 32'(current_beat), 32'd6);
    check("resume_track_play_b5", 32'(track_play), 32'h2);
    cyc();
    check("resume_track_play_b6", 32'(track_play), 32'h4);

    // Stop + play together with a pending tick: stop wins, no tick.
    cyc();
    cyc();
    stop_cmd = 1'b1;
    play_cmd = 1'b1;
    cyc();
    stop_cmd = 1'b0;
    play_cmd = 1'b0;
    check("stop_wins_state", 32'(run_state), 32'd0);
    check("stop_wins_beat", 32'(current_beat), 32'd0);
    check("stop_wins_no_tick", 32'(beat_tick), 32'd0);
    cyc();
    check("stopped_track_play", 32'(track_play), 32'h0);

    // Restart gives beat 0 a full period; lowering tempo ticks at once.
    exp_beats.push_back(4'd1);
    pulse_play();
    repeat (3) cyc();
    check("restart_full_period", 32'(current_beat), 32'd0);
    cyc();
    check("restart_first_tick", 32'(current_beat), 32'd1);
    cyc();
    cyc();
    tempo_div = 26'd1;
    exp_beats.push_back(4'd2);
    cyc();
    check("tempo_lowered_tick", 32'(current_beat), 32'd2);
    pulse_stop();
    check("stopped_again", 32'(run_state), 32'd0);

    // load_req held 10 cycles: one write, ack held, later data ignored.
    track_sel = 2'd3;
    pattern   = 16'hA5A5;
    load_req  = 1'b1;
    exp_loads.push_back(16'hA5A5);
    for (int i = 1; i <= 10; i++) begin
      cyc();
      check("held_req_ack", 32'(load_ack), 32'd1);
      if (i == 2) pattern = 16'hFFFF;
    end
    load_req = 1'b0;
    check("held_req_ack_still_high", 32'(load_ack), 32'd1);
    cyc();
    check("held_req_ack_fell", 32'(load_ack), 32'd0);
    check("held_req_single_write", 32'(pattern_view), 32'hA5A5);

    // Tempo 0: tick every cycle, wrap 15->0, load coincident with a tick.
    tempo_div = 26'd0;
    for (int b = 1; b <= 20; b++) exp_beats.push_back(4'(b % 16));
    pulse_play();
    for (int k = 1; k <= 20; k++) begin
      cyc();
      if (k == 5) begin
        track_sel = 2'd0;
        pattern   = 16'h0180;
        load_req  = 1'b1;
        exp_loads.push_back(16'h0180);
      end
      if (k == 6) begin
        check("tick_load_ack", 32'(load_ack), 32'd1);
        load_req = 1'b0;
      end
      if (k == 7) begin
        check("tick_load_ack_fall", 32'(load_ack), 32'd0);
        check("fast_track_play_b6", 32'(track_play), 32'h4);
      end
      if (k == 8) check("fast_track_play_b7", 32'(track_play), 32'h9);
      if (k == 9) check("fast_track_play_b8", 32'(track_play), 32'h9);
      if (k == 10) check("fast_track_play_b9", 32'(track_play), 32'h0);
      if (k == 16) check("fast_wrap", 32'(current_beat), 32'd0);
    end
    @(negedge clock);
    #1;
    reset = 1'b1;
    #1;
    check_idle_outputs("mid_bar_reset");
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    cyc();
    check_idle_outputs("post_mid_bar_reset");

    repeat (3) cyc();
    check("beat_queue_drained", 32'(exp_beats.size()), 32'd0);
    check("load_queue_drained", 32'(exp_loads.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/beat_sequencer.md
BEAT_SEQUENCER -- requirements
Module: beat_sequencer

Interface
REQ-001 Parameter NUM_TRACKS, default 4: number of speaker tracks sequenced.
REQ-002 Parameter STEPS, default 16: beats per bar; fixed power of two.
REQ-003 Parameter DIV_WIDTH, default 26: width of tempo divider.
REQ-004 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-005 clock  in  1  system clock; all state changes on rising edge.
REQ-006 reset  in  1  asynchronous, active-high reset.
REQ-007 pattern  in  STEPS  step pattern to store; bit n = play on beat n.
REQ-008 track_sel  in  log2(NUM_TRACKS)  target track for pattern load.
REQ-009 load_req  in  1  four-phase load request.
REQ-010 load_ack  out  1  four-phase load acknowledge.
REQ-011 play_cmd  in  1  one-cycle pulse: start/pause/resume.
REQ-012 stop_cmd  in  1  one-cycle pulse: stop and rewind.
REQ-013 tempo_div  in  DIV_WIDTH  beat period minus one, in clock cycles.
REQ-014 beat_tick  out  1  one-cycle pulse on each beat advance.
REQ-015 current_beat  out  log2(STEPS)  beat index, drives green LEDs.
REQ-016 track_play  out  NUM_TRACKS  per-track speaker enable, registered.
REQ-017 run_state  out  2  encoded FSM state.
REQ-018 pattern_view  out  STEPS  stored pattern of track_sel, drives red LEDs, combinational.

Function
REQ-019 FSM states: STOPPED, RUNNING, PAUSED.
REQ-020 play_cmd: STOPPED->RUNNING, RUNNING->PAUSED, PAUSED->RUNNING.
REQ-021 stop_cmd from any state: ->STOPPED, current_beat=0, divider count=0, next cycle.
REQ-022 stop_cmd and play_cmd in same cycle: stop_cmd wins.
REQ-023 Divider counts only in RUNNING, holds in PAUSED, is cleared in STOPPED.
REQ-024 beat_tick pulses when count >= tempo_div; count then returns to 0 (period tempo_div+1 cycles; tempo_div=0 ticks every cycle).
REQ-025 Lowering tempo_div below the current count produces a tick on the next RUNNING cycle; no wrap-through.
REQ-026 current_beat increments by 1 on each beat_tick, wrapping STEPS-1 -> 0.
REQ-027 On entry from STOPPED, beat 0 sounds for a full period before the first tick.
REQ-028 track_play[t] SHALL equal (state==RUNNING) & pattern_reg[t][current_beat], registered with 1-cycle latency.
REQ-029 In PAUSED and STOPPED, track_play SHALL be 0.
REQ-030 Load: when load_req=1 and load_ack=0, write pattern to pattern_reg[track_sel]; load_ack rises the next cycle.
REQ-031 load_ack stays high until load_req is sampled low, then falls the next cycle; no new write while load_ack=1.
REQ-032 Loads SHALL be accepted in every state; a write to the playing track affects track_play one cycle after the write.
REQ-033 A tick and a load in the same cycle both take effect; neither is dropped.

Reset
REQ-034 Reset SHALL force: state=STOPPED, divider=0, current_beat=0, all pattern_reg=0, track_play=0, beat_tick=0, load_ack=0.
REQ-035 Reset mid-run or mid-handshake SHALL abort the operation; the requester must re-raise load_req after reset.

Structure
REQ-036 Shared package beat_seq_pkg SHALL hold the state enum and the default NUM_TRACKS/STEPS/DIV_WIDTH constants.
REQ-037 Divider and tick generation SHALL be a sub-module tempo_divider (inputs: run, clear, tempo_div; output: tick).

Verification
REQ-038 Load track 0 = 16'h8001, tempo_div=3, play -> ticks every 4 cycles; track_play[0]=1 during beats 0 and 15 only.
REQ-039 Play, then play again after beat 5 -> PAUSED; beat holds at 5, track_play=0; third play resumes at the same divider count.
REQ-040 stop_cmd coincident with beat_tick and play_cmd -> STOPPED next cycle, current_beat=0, no tick counted.
REQ-041 load_req held 10 cycles -> exactly one write, load_ack high from cycle 2 until 1 cycle after req drops.
REQ-042 Run with tempo_div=0 -> beat wraps 15->0 every 16 cycles; assert reset mid-bar -> all outputs and patterns 0.
